// File: rtl/seg_scan_driver.sv
// Time-multiplexed scan driver for the 4-digit BASYS 3 seven-segment display.
// Each digit slot begins with a blanking interval before its anode is strobed.
module seg_scan_driver #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int CNT_W        = 17
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       blank_lz,
    input  logic [3:0] Y,
    output logic [1:0] Q,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       q_nxt;
    logic [3:0]       an_nxt;
    logic             slot_end;
    logic             lz_hide;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] anode_of(input logic [1:0] sel);
        logic [3:0] a;
        case (sel)
            2'd0:    a = 4'b0111;
            2'd1:    a = 4'b1011;
            2'd2:    a = 4'b1101;
            default: a = 4'b1110;
        endcase
        return a;
    endfunction

    // an is computed from the next-cycle state so that it lines up with the state
    // register; the digit it displays is the Y being captured into seg on that edge.
    always_comb begin
        slot_end  = (cnt == SLOT_LAST);
        cnt_nxt   = slot_end ? '0 : cnt + 1'b1;
        q_nxt     = slot_end ? Q + 2'd1 : Q;
        state_nxt = state;
        case (state)
            ST_BLANK: if (cnt == BLANK_LAST) state_nxt = ST_ON;
            ST_ON:    if (slot_end)          state_nxt = ST_BLANK;
            default:  state_nxt = ST_BLANK;
        endcase
        lz_hide = blank_lz && !q_nxt[0] && (Y == 4'd0);
        an_nxt  = 4'b1111;
        if (en && (state_nxt == ST_ON) && !lz_hide)
            an_nxt = anode_of(q_nxt);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            Q          <= 2'd0;
            state      <= ST_BLANK;
            an         <= 4'b1111;
            seg        <= 7'b1111111;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            Q          <= q_nxt;
            state      <= state_nxt;
            an         <= an_nxt;
            seg        <= decode(Y);
            dp         <= 1'b1;
            frame_tick <= slot_end && (Q == 2'd3);
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: a slot/frame arithmetic model predicts every output
// each cycle, alongside a decode table and hand-built corner-case sequences.
module tb_seg_scan_driver;

    localparam int RD = 8;
    localparam int BC = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       blank_lz;
    logic [3:0] Y;
    logic [1:0] Q;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;

    int nCompared   = 0;
    int nMismatched = 0;
    int k           = 0;
    logic       prevEn, prevLz;
    logic [3:0] prevY;
    int ftCount;

    typedef struct {
        logic [3:0] y;
        logic [6:0] expSeg;
    } decVec_t;
    decVec_t decTbl[16];

    seg_scan_driver #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .en(en), .blank_lz(blank_lz), .Y(Y),
        .Q(Q), .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] expSegOf(input int v);
        case (v)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    function automatic int slotPos(input int t);
        return t % RD;
    endfunction

    function automatic int digitSel(input int t);
        return (t / RD) % 4;
    endfunction

    task automatic compareVal(input string name, input int act, input int exp);
        nCompared++;
        if (act != exp) begin
            nMismatched++;
            $display("[TB] FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Expected outputs after k edges since reset release, from the slot arithmetic
    task automatic checkOutput();
        int pos, sel;
        logic [3:0] expAn;
        pos = slotPos(k);
        sel = digitSel(k);
        expAn = 4'b1111;
        if (prevEn && pos >= BC && !(prevLz && (sel % 2 == 0) && prevY == 4'd0))
            expAn = ~(4'b1000 >> sel);
        compareVal("Q", int'(Q), sel);
        compareVal("an", int'(an), int'(expAn));
        compareVal("seg", int'(seg), int'(expSegOf(int'(prevY))));
        compareVal("dp", int'(dp), 1);
        compareVal("frame_tick", int'(frame_tick), (k > 0 && k % (4 * RD) == 0) ? 1 : 0);
    endtask

    task automatic applyStimulus(input logic e, input logic lz, input logic [3:0] y);
        en = e;
        blank_lz = lz;
        Y = y;
        prevEn = e;
        prevLz = lz;
        prevY = y;
        @(posedge clk);
        #1;
        k++;
        if (frame_tick) ftCount++;
        checkOutput();
    endtask

    // Bench-side digit mux: Y follows the digit the model says is selected
    task automatic applyMux(input logic e, input logic lz, input logic [3:0] d0,
                            input logic [3:0] d1, input logic [3:0] d2, input logic [3:0] d3);
        logic [3:0] y;
        case (digitSel(k))
            0: y = d0;
            1: y = d1;
            2: y = d2;
            default: y = d3;
        endcase
        applyStimulus(e, lz, y);
    endtask

    task automatic checkResetValues(input string tag);
        compareVal({tag, "_an"}, int'(an), 4'hF);
        compareVal({tag, "_seg"}, int'(seg), 7'h7F);
        compareVal({tag, "_Q"}, int'(Q), 0);
        compareVal({tag, "_dp"}, int'(dp), 1);
        compareVal({tag, "_ft"}, int'(frame_tick), 0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            decTbl[i].y = 4'(i);
        end
        decTbl[0].expSeg  = 7'b1000000;  decTbl[1].expSeg  = 7'b1111001;
        decTbl[2].expSeg  = 7'b0100100;  decTbl[3].expSeg  = 7'b0110000;
        decTbl[4].expSeg  = 7'b0011001;  decTbl[5].expSeg  = 7'b0010010;
        decTbl[6].expSeg  = 7'b0000010;  decTbl[7].expSeg  = 7'b1111000;
        decTbl[8].expSeg  = 7'b0000000;  decTbl[9].expSeg  = 7'b0010000;
        for (int i = 10; i < 16; i++) decTbl[i].expSeg = 7'b0111111;

        reset = 1'b1;
        en = 1'b1;
        blank_lz = 1'b0;
        Y = 4'd8;
        #12;
        checkResetValues("reset");
        reset = 1'b0;
        k = 0;

        // One full frame with a fixed 8: blanking, anode sequence and one frame tick
        ftCount = 0;
        for (int i = 0; i < 4 * RD; i++) applyStimulus(1'b1, 1'b0, 4'd8);
        compareVal("ft_per_frame", ftCount, 1);

        for (int i = 0; i < 4 * RD; i++) applyMux(1'b1, 1'b0, 4'd1, 4'd2, 4'd3, 4'd4);

        // Leading-zero blanking on time tens, then the same digits unblanked
        for (int i = 0; i < 4 * RD; i++) applyMux(1'b1, 1'b1, 4'd0, 4'd7, 4'd5, 4'd3);
        for (int i = 0; i < 4 * RD; i++) applyMux(1'b1, 1'b0, 4'd0, 4'd7, 4'd5, 4'd3);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b0, decTbl[i].y);
            compareVal("decode_tbl", int'(seg), int'(decTbl[i].expSeg));
        end

        for (int i = 0; i < RD; i++) applyStimulus(1'b1, 1'b0, 4'd12);

        // Display disabled for a full frame, then re-enabled at slot position 3 of Q=01
        ftCount = 0;
        for (int i = 0; i < 4 * RD; i++) applyStimulus(1'b0, 1'b0, 4'd6);
        compareVal("ft_while_disabled", ftCount, 1);
        for (int i = 0; i < 8 * RD && !(slotPos(k) == 3 && digitSel(k) == 1); i++)
            applyStimulus(1'b0, 1'b0, 4'd6);
        compareVal("reenable_pos", slotPos(k) * 4 + digitSel(k), 13);
        applyStimulus(1'b1, 1'b0, 4'd6);
        compareVal("reenable_an", int'(an), 4'b1011);
        for (int i = 0; i < RD; i++) applyStimulus(1'b1, 1'b0, 4'd6);

        // Asynchronous reset in the middle of an ON phase
        for (int i = 0; i < 4 * RD && slotPos(k) != 4; i++) applyStimulus(1'b1, 1'b0, 4'd2);
        compareVal("midon_an_before", int'(an == 4'b1111), 0);
        reset = 1'b1;
        #1;
        checkResetValues("midon");
        @(posedge clk);
        #1;
        checkResetValues("held");
        reset = 1'b0;
        k = 0;
        for (int i = 0; i < 2 * RD; i++) applyStimulus(1'b1, 1'b0, 4'd9);

        for (int i = 0; i < 400; i++)
            applyStimulus(($urandom_range(0, 7) != 0), 1'($urandom), 4'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
